spike_rate_encoder: RTL and testbench

Converts a multi-bit intensity value into a rate-coded spike train that lasts one spiking window of SPIKING_WINDOW cycles. Its output drives the pre_spike input of downstream synapse instances, so it is the producer end of the spike-train interface the synapse consumes. Values arrive through a valid/ready handshake. Two coding modes: deterministic (evenly spaced spikes from an accumulator) and stochastic (LFSR comparison).

---
 rtl/neuron_pkg.sv | 27 ++
 rtl/spike_lfsr16.sv | 29 ++
 rtl/spike_rate_encoder.sv | 111 +++++++++++
 tb/tb_spike_rate_encoder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
`default_nettype none
// ============================================================================
// Module   : neuron_pkg
// Brief    : Shared types and helpers for the spike rate encoder.
// Revision : 1.0 - initial release
// ============================================================================
package neuron_pkg;

  typedef enum logic {
    ENC_DET   = 1'b0,
    ENC_STOCH = 1'b1
  } encode_mode_e;

  typedef enum logic {
    IDLE   = 1'b0,
    ENCODE = 1'b1
  } enc_state_e;

  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

  // Width needed to hold a count of 0..w spikes.
  function automatic int spike_cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/spike_lfsr16.sv
`default_nettype none
// ============================================================================
// Module   : spike_lfsr16
// Brief    : 16-bit Fibonacci LFSR (taps 16,14,13,11), steps when advance=1.
// Revision : 1.0 - initial release
// ============================================================================
module spike_lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        advance,
  output logic [15:0] state
);

  logic w_feedback;

  assign w_feedback = state[15] ^ state[13] ^ state[12] ^ state[10];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEED;
    end else if (advance) begin
      state <= {state[14:0], w_feedback};
    end
  end

endmodule
`default_nettype wire

// File: rtl/spike_rate_encoder.sv
`default_nettype none
// ============================================================================
// Module   : spike_rate_encoder
// Brief    : Rate-codes an intensity into a SPIKING_WINDOW-slot spike train.
// Revision : 1.0 - initial release
// ============================================================================
module spike_rate_encoder
  import neuron_pkg::*;
#(
  parameter int          SPIKING_WINDOW = 16,
  parameter int          VALUE_W        = 8,
  parameter logic [15:0] LFSR_SEED      = LFSR_SEED_DEFAULT
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [VALUE_W-1:0]                     in_value,
  input  logic                                   in_mode,
  input  logic                                   flush,
  output logic                                   spike_out,
  output logic                                   busy,
  output logic                                   window_start,
  output logic                                   window_end,
  output logic [spike_cnt_w(SPIKING_WINDOW)-1:0] spike_count
);

  localparam int                 c_CNT_W     = $clog2(SPIKING_WINDOW);
  localparam int                 c_SC_W      = spike_cnt_w(SPIKING_WINDOW);
  localparam logic [c_CNT_W-1:0] c_LAST_SLOT = c_CNT_W'(SPIKING_WINDOW - 1);
  localparam logic [VALUE_W-1:0] c_HALF      = VALUE_W'(2 ** (VALUE_W - 1));
  localparam logic [15:0]        c_LFSR_MASK = 16'((32'd1 << VALUE_W) - 32'd1);

  enc_state_e         r_state;
  encode_mode_e       r_mode;
  logic [c_CNT_W-1:0] r_cnt;
  logic [VALUE_W-1:0] r_acc;
  logic [VALUE_W-1:0] r_value;
  logic [c_SC_W-1:0]  r_win_spikes;
  logic [c_SC_W-1:0]  r_spike_count;

  logic [15:0]        w_lfsr;
  logic [VALUE_W:0]   w_sum;
  logic               w_det_spike;
  logic               w_stoch_spike;
  logic               w_spike;
  logic               w_busy;
  logic               w_last;
  logic               w_accept;

  spike_lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (w_busy),
    .state   (w_lfsr)
  );

  // Accumulator carry-out marks a spike; the remainder carries to the next slot.
  assign w_sum         = {1'b0, r_acc} + {1'b0, r_value};
  assign w_det_spike   = w_sum[VALUE_W];
  assign w_stoch_spike = (w_lfsr & c_LFSR_MASK) < 16'(r_value);
  assign w_spike       = (r_mode == ENC_STOCH) ? w_stoch_spike : w_det_spike;

  assign w_busy   = (r_state == ENCODE);
  assign w_last   = w_busy && (r_cnt == c_LAST_SLOT);
  assign in_ready = (r_state == IDLE) || (w_last && !flush);
  assign w_accept = in_valid && in_ready;

  assign busy         = w_busy;
  assign spike_out    = w_busy && w_spike;
  assign window_start = w_busy && (r_cnt == '0);
  assign window_end   = w_last;
  assign spike_count  = r_spike_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_mode        <= ENC_DET;
      r_cnt         <= '0;
      r_acc         <= '0;
      r_value       <= '0;
      r_win_spikes  <= '0;
      r_spike_count <= '0;
    end else begin
      if (w_busy) begin
        r_acc        <= w_sum[VALUE_W-1:0];
        r_cnt        <= r_cnt + c_CNT_W'(1);
        r_win_spikes <= r_win_spikes + c_SC_W'(w_spike);
        if (w_last && !flush) begin
          r_spike_count <= r_win_spikes + c_SC_W'(w_spike);
        end
        if (flush || w_last) begin
          r_state <= IDLE;
        end
      end
      // A last-slot accept overrides the return to IDLE, chaining windows.
      if (w_accept) begin
        r_state      <= ENCODE;
        r_mode       <= encode_mode_e'(in_mode);
        r_value      <= in_value;
        r_acc        <= c_HALF;
        r_cnt        <= '0;
        r_win_spikes <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spike_rate_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_spike_rate_encoder
// Brief    : Directed self-checking bench for spike_rate_encoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spike_rate_encoder;

  localparam logic [15:0] c_SEED = 16'hACE1;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_value;
  logic       in_mode;
  logic       flush;
  logic       spike_out;
  logic       busy;
  logic       window_start;
  logic       window_end;
  logic [4:0] spike_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] m_lfsr;
  logic [15:0] pat1;
  logic [15:0] pat2;
  logic [15:0] exp_pat;
  logic        busy_ok;

  spike_rate_encoder #(
    .SPIKING_WINDOW (16),
    .VALUE_W        (8),
    .LFSR_SEED      (c_SEED)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_value     (in_value),
    .in_mode      (in_mode),
    .flush        (flush),
    .spike_out    (spike_out),
    .busy         (busy),
    .window_start (window_start),
    .window_end   (window_end),
    .spike_count  (spike_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] m);
    return {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
  endfunction

  function automatic logic [15:0] lfsr_adv16(input logic [15:0] m);
    logic [15:0] t;
    t = m;
    for (int i = 0; i < 16; i++) t = lfsr_next(t);
    return t;
  endfunction

  function automatic logic [15:0] stoch_pat(input logic [15:0] m, input logic [7:0] v);
    logic [15:0] t;
    logic [15:0] p;
    t = m;
    p = '0;
    for (int s = 0; s < 16; s++) begin
      p[s] = (t[7:0] < v);
      t = lfsr_next(t);
    end
    return p;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called at a negedge with the encoder idle; returns at the negedge after the window.
  task automatic run_win(input string tag, input logic [7:0] v, input logic m,
                         input logic [15:0] expp);
    logic [15:0] pat;
    pat = '0;
    check({tag, "_ready"}, in_ready, 1'b1);
    in_valid = 1'b1;
    in_value = v;
    in_mode  = m;
    @(negedge clk);
    in_valid = 1'b0;
    in_value = 8'hA5;
    for (int s = 0; s < 16; s++) begin
      if (s == 0) begin
        check({tag, "_wstart"}, window_start, 1'b1);
        check({tag, "_busy"}, busy, 1'b1);
      end
      if (s == 15) check({tag, "_wend"}, window_end, 1'b1);
      pat[s] = spike_out;
      @(negedge clk);
    end
    check({tag, "_pattern"}, pat, expp);
    check({tag, "_count"}, spike_count, $countones(expp));
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_value = '0;
    in_mode  = 1'b0;
    flush    = 1'b0;
    do_reset();

    check("rst_ready", in_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_spike", spike_out, 1'b0);
    check("rst_count", spike_count, 5'd0);
    check("rst_wstart", window_start, 1'b0);

    // Deterministic windows with hand-derived slot patterns.
    run_win("det128", 8'd128, 1'b0, 16'h5555);
    run_win("det0",   8'd0,   1'b0, 16'h0000);
    run_win("det255", 8'd255, 1'b0, 16'hFFFF);
    run_win("det16",  8'd16,  1'b0, 16'h0080);

    // Back-to-back: 64 then 192 with in_valid held across the boundary.
    busy_ok  = 1'b1;
    pat1     = '0;
    pat2     = '0;
    in_valid = 1'b1;
    in_value = 8'd64;
    in_mode  = 1'b0;
    @(negedge clk);
    in_value = 8'd192;
    for (int s = 0; s < 16; s++) begin
      if (!busy) busy_ok = 1'b0;
      pat1[s] = spike_out;
      if (s == 15) begin
        check("b2b_wend1", window_end, 1'b1);
        check("b2b_ready_last", in_ready, 1'b1);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("b2b_wstart2", window_start, 1'b1);
    check("b2b_count1", spike_count, 5'd4);
    check("b2b_pat1", pat1, 16'h2222);
    for (int s = 0; s < 16; s++) begin
      if (!busy) busy_ok = 1'b0;
      pat2[s] = spike_out;
      @(negedge clk);
    end
    check("b2b_busy_held", busy_ok, 1'b1);
    check("b2b_pat2", pat2, 16'hBBBB);
    check("b2b_count2", spike_count, 5'd12);

    // Flush at slot 5 of a value-200 window.
    in_valid = 1'b1;
    in_value = 8'd200;
    in_mode  = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("fl_busy_s5", busy, 1'b1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("fl_busy", busy, 1'b0);
    check("fl_spike", spike_out, 1'b0);
    check("fl_wend", window_end, 1'b0);
    check("fl_count", spike_count, 5'd12);
    @(negedge clk);
    check("fl_ready", in_ready, 1'b1);
    check("fl_count_hold", spike_count, 5'd12);

    // Stochastic windows from a fresh seed; LFSR runs on across windows.
    do_reset();
    m_lfsr = c_SEED;
    run_win("st255", 8'd255, 1'b1, stoch_pat(m_lfsr, 8'd255));
    m_lfsr = lfsr_adv16(m_lfsr);
    run_win("st0", 8'd0, 1'b1, 16'h0000);
    m_lfsr = lfsr_adv16(m_lfsr);
    run_win("st128_cont", 8'd128, 1'b1, stoch_pat(m_lfsr, 8'd128));

    // Asynchronous reset mid-window, then the sequence restarts from the seed.
    in_valid = 1'b1;
    in_value = 8'd128;
    in_mode  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("ar_busy", busy, 1'b0);
    check("ar_spike", spike_out, 1'b0);
    check("ar_ready", in_ready, 1'b1);
    check("ar_count", spike_count, 5'd0);
    check("ar_wstart", window_start, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_pat = stoch_pat(c_SEED, 8'd128);
    run_win("st_after_rst", 8'd128, 1'b1, exp_pat);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
